// File: rtl/trap_peak_detector.sv
// Pulse detector for the trapezoidal filter stream: measures peak, time over threshold and
// arrival time per pulse, flags pile-up, and hands one record per pulse to readout.
module trap_peak_detector #(
   parameter int DATA_W  = 18,
   parameter int TS_W    = 32,
   parameter int HOLDOFF = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] threshold,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_amp,
   output logic [TS_W-1:0]          out_ts,
   output logic [15:0]              out_width,
   output logic                     out_pileup,
   output logic                     overflow,
   output logic                     busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ABOVE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0]      HOLD_INIT = 8'(HOLDOFF);
   localparam logic [TS_W-1:0] TS_ONE    = {{(TS_W-1){1'b0}}, 1'b1};

   state_t                   state_q, state_d;
   logic [TS_W-1:0]          ts_q, ts_d;
   logic [TS_W-1:0]          ev_ts_q, ev_ts_d;
   logic signed [DATA_W-1:0] ev_max_q, ev_max_d;
   logic [15:0]              ev_width_q, ev_width_d;
   logic                     ev_pile_q, ev_pile_d;
   logic [7:0]               hold_q, hold_d;

   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_amp_q, out_amp_d;
   logic [TS_W-1:0]          out_ts_q, out_ts_d;
   logic [15:0]              out_width_q, out_width_d;
   logic                     out_pileup_q, out_pileup_d;
   logic                     overflow_q, overflow_d;
   logic                     busy_q, busy_d;

   logic                     above_s;
   logic                     below_s;
   logic                     complete_s;

   // Next-state logic for the timestamp, the pulse measurement FSM and the record handshake.
   always_comb begin
      above_s    = in_valid && (in_data > threshold);
      below_s    = in_valid && !(in_data > threshold);
      ts_d       = ts_q + TS_ONE;
      state_d    = state_q;
      ev_ts_d    = ev_ts_q;
      ev_max_d   = ev_max_q;
      ev_width_d = ev_width_q;
      ev_pile_d  = ev_pile_q;
      hold_d     = hold_q;
      complete_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (above_s) begin
               state_d    = ST_ABOVE;
               ev_ts_d    = ts_q;
               ev_max_d   = in_data;
               ev_width_d = 16'd1;
               ev_pile_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ABOVE: begin
            if (above_s) begin
               if (ev_width_q != 16'hFFFF) begin
                  ev_width_d = ev_width_q + 16'd1;
               end else begin
                  ev_width_d = ev_width_q;
               end
               // strict compare keeps the earliest sample on a flat top
               if (in_data > ev_max_q) begin
                  ev_max_d = in_data;
               end else begin
                  ev_max_d = ev_max_q;
               end
            end else if (below_s) begin
               complete_s = 1'b1;
               hold_d     = HOLD_INIT;
               state_d    = ST_HOLD;
            end else begin
               state_d = ST_ABOVE;
            end
         end
         ST_HOLD: begin
            if (above_s) begin
               state_d    = ST_ABOVE;
               ev_ts_d    = ts_q;
               ev_max_d   = in_data;
               ev_width_d = 16'd1;
               ev_pile_d  = 1'b1;
            end else if (below_s) begin
               if (hold_q <= 8'd1) begin
                  hold_d  = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  hold_d  = hold_q - 8'd1;
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = 8'd0;
         end
      endcase

      out_valid_d  = out_valid_q;
      out_amp_d    = out_amp_q;
      out_ts_d     = out_ts_q;
      out_width_d  = out_width_q;
      out_pileup_d = out_pileup_q;
      overflow_d   = overflow_q;

      if (complete_s) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d  = 1'b1;
            out_amp_d    = ev_max_q;
            out_ts_d     = ev_ts_q;
            out_width_d  = ev_width_q;
            out_pileup_d = ev_pile_q;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset discards any partially measured pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ts_q         <= '0;
         ev_ts_q      <= '0;
         ev_max_q     <= '0;
         ev_width_q   <= 16'd0;
         ev_pile_q    <= 1'b0;
         hold_q       <= 8'd0;
         out_valid_q  <= 1'b0;
         out_amp_q    <= '0;
         out_ts_q     <= '0;
         out_width_q  <= 16'd0;
         out_pileup_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ts_q         <= ts_d;
         ev_ts_q      <= ev_ts_d;
         ev_max_q     <= ev_max_d;
         ev_width_q   <= ev_width_d;
         ev_pile_q    <= ev_pile_d;
         hold_q       <= hold_d;
         out_valid_q  <= out_valid_d;
         out_amp_q    <= out_amp_d;
         out_ts_q     <= out_ts_d;
         out_width_q  <= out_width_d;
         out_pileup_q <= out_pileup_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_amp    = out_amp_q;
   assign out_ts     = out_ts_q;
   assign out_width  = out_width_q;
   assign out_pileup = out_pileup_q;
   assign overflow   = overflow_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_trap_peak_detector.sv
// Directed bench for trap_peak_detector: a 32-bit timestamp instance and an 8-bit one
// share all inputs, so the narrow one exercises timestamp wrap-around.
module tb_trap_peak_detector;

   localparam int DW = 18;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [DW-1:0] in_data;
   logic                 in_valid;
   logic signed [DW-1:0] threshold;
   logic                 out_ready;

   logic                 o_valid, o_pile, o_ovf, o_busy;
   logic signed [DW-1:0] o_amp;
   logic [31:0]          o_ts;
   logic [15:0]          o_width;

   logic                 o8_valid, o8_pile, o8_ovf, o8_busy;
   logic signed [DW-1:0] o8_amp;
   logic [7:0]           o8_ts;
   logic [15:0]          o8_width;

   int compared   = 0;
   int mismatched = 0;
   int cnt        = 0;

   always #5 clk = ~clk;

   trap_peak_detector #(.DATA_W(DW), .TS_W(32), .HOLDOFF(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .threshold(threshold), .out_valid(o_valid), .out_ready(out_ready),
      .out_amp(o_amp), .out_ts(o_ts), .out_width(o_width), .out_pileup(o_pile),
      .overflow(o_ovf), .busy(o_busy)
   );

   trap_peak_detector #(.DATA_W(DW), .TS_W(8), .HOLDOFF(4)) dut8 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .threshold(threshold), .out_valid(o8_valid), .out_ready(out_ready),
      .out_amp(o8_amp), .out_ts(o8_ts), .out_width(o8_width), .out_pileup(o8_pile),
      .overflow(o8_ovf), .busy(o8_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // cnt tracks the timestamp value the DUT sees for the sample driven here
   task automatic tick(input logic signed [DW-1:0] d, input logic v);
      in_data  = d;
      in_valid = v;
      @(posedge clk);
      #1;
      cnt++;
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = 18'sd0;
      in_valid  = 1'b0;
      threshold = 18'sd100;
      out_ready = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_ts", o_ts, 32'd0);
      chk("rst_cnt", dut.ts_q, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      cnt = 0;

      // basic pulse: 0,0 at 10,11 then 150..50 at 12..17
      while (cnt < 12) tick(18'sd0, 1'b1);
      tick(18'sd150, 1'b1);
      chk("t1_busy_rise", 32'(o_busy), 32'd1);
      tick(18'sd300, 1'b1);
      tick(18'sd500, 1'b1);
      tick(18'sd500, 1'b1);
      tick(18'sd200, 1'b1);
      chk("t1_no_early_rec", 32'(o_valid), 32'd0);
      tick(18'sd50, 1'b1);
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_amp", 32'(o_amp), 32'd500);
      chk("t1_ts", o_ts, 32'd12);
      chk("t1_width", 32'(o_width), 32'd5);
      chk("t1_pile", 32'(o_pile), 32'd0);
      tick(18'sd0, 1'b1);
      chk("t1_accepted", 32'(o_valid), 32'd0);
      tick(18'sd0, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t1_busy_hold", 32'(o_busy), 32'd1);
      tick(18'sd0, 1'b1);
      chk("t1_busy_fall", 32'(o_busy), 32'd0);

      // pile-up: 150,300,50 at 22..24, 0 at 25, 120 at 26, 0 at 27
      tick(18'sd150, 1'b1);
      tick(18'sd300, 1'b1);
      tick(18'sd50, 1'b1);
      chk("t2a_amp", 32'(o_amp), 32'd300);
      chk("t2a_ts", o_ts, 32'd22);
      chk("t2a_width", 32'(o_width), 32'd2);
      chk("t2a_pile", 32'(o_pile), 32'd0);
      tick(18'sd0, 1'b1);
      chk("t2a_accepted", 32'(o_valid), 32'd0);
      tick(18'sd120, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t2b_valid", 32'(o_valid), 32'd1);
      chk("t2b_amp", 32'(o_amp), 32'd120);
      chk("t2b_ts", o_ts, 32'd26);
      chk("t2b_width", 32'(o_width), 32'd1);
      chk("t2b_pile", 32'(o_pile), 32'd1);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);
      chk("t2_idle", 32'(o_busy), 32'd0);

      // back-pressure: pulse A at 32, pulse B at 38 is dropped
      out_ready = 1'b0;
      tick(18'sd200, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t3a_valid", 32'(o_valid), 32'd1);
      chk("t3a_amp", 32'(o_amp), 32'd200);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);
      chk("t3_held_valid", 32'(o_valid), 32'd1);
      chk("t3_no_ovf_yet", 32'(o_ovf), 32'd0);
      tick(18'sd300, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t3_ovf", 32'(o_ovf), 32'd1);
      chk("t3_held_amp", 32'(o_amp), 32'd200);
      chk("t3_held_ts", o_ts, 32'd32);
      chk("t3_held_width", 32'(o_width), 32'd1);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);
      chk("t3_still_valid", 32'(o_valid), 32'd1);
      out_ready = 1'b1;
      tick(18'sd0, 1'b1);
      chk("t3_drained", 32'(o_valid), 32'd0);
      chk("t3_ovf_sticky", 32'(o_ovf), 32'd1);

      // negative, sparse: -100@45, -20@47, -10@49, -60@51; invalid cycles carry 500
      threshold = -18'sd50;
      tick(-18'sd100, 1'b1);
      tick(18'sd500, 1'b0);
      chk("t4_invalid_ignored", 32'(o_busy), 32'd0);
      tick(-18'sd20, 1'b1);
      tick(18'sd500, 1'b0);
      tick(-18'sd10, 1'b1);
      tick(18'sd500, 1'b0);
      tick(-18'sd60, 1'b1);
      chk("t4_valid", 32'(o_valid), 32'd1);
      chk("t4_amp", 32'(o_amp), 32'(-18'sd10));
      chk("t4_width", 32'(o_width), 32'd2);
      chk("t4_ts", o_ts, 32'd47);
      chk("t4_pile", 32'(o_pile), 32'd0);
      tick(-18'sd100, 1'b1);
      tick(18'sd500, 1'b0);
      tick(-18'sd100, 1'b1);
      tick(18'sd500, 1'b0);
      tick(-18'sd100, 1'b1);
      chk("t4_hold_sparse", 32'(o_busy), 32'd1);
      tick(-18'sd100, 1'b1);
      chk("t4_idle", 32'(o_busy), 32'd0);
      threshold = 18'sd100;
      tick(18'sd0, 1'b1);

      // reset in the middle of a pulse
      tick(18'sd150, 1'b1);
      tick(18'sd300, 1'b1);
      chk("t5_pre_busy", 32'(o_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_busy", 32'(o_busy), 32'd0);
      chk("t5_ovf", 32'(o_ovf), 32'd0);
      chk("t5_amp", 32'(o_amp), 32'd0);
      chk("t5_ts", o_ts, 32'd0);
      chk("t5_width", 32'(o_width), 32'd0);
      chk("t5_cnt", dut.ts_q, 32'd0);
      in_data = 18'sd300;
      @(posedge clk);
      #2 reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) tick(18'sd0, 1'b1);
      chk("t5_no_record", 32'(o_valid), 32'd0);
      tick(18'sd400, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t5_rec_valid", 32'(o_valid), 32'd1);
      chk("t5_rec_amp", 32'(o_amp), 32'd400);
      chk("t5_rec_ts", o_ts, 32'd3);
      chk("t5_rec_width", 32'(o_width), 32'd1);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);

      // 8-bit timestamp wrap: pulse starts at counter 255
      while (cnt < 255) tick(18'sd0, 1'b1);
      tick(18'sd250, 1'b1);
      chk("t6_cnt8_wrapped", 32'(dut8.ts_q), 32'd0);
      chk("t6_cnt32", dut.ts_q, 32'd256);
      chk("t6_busy8", 32'(o8_busy), 32'd1);
      tick(18'sd0, 1'b1);
      chk("t6_valid8", 32'(o8_valid), 32'd1);
      chk("t6_ts8", 32'(o8_ts), 32'd255);
      chk("t6_ts32", o_ts, 32'd255);
      chk("t6_amp8", 32'(o8_amp), 32'd250);
      chk("t6_pile8", 32'(o8_pile), 32'd0);
      chk("t6_ovf8", 32'(o8_ovf), 32'd0);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);

      // width saturation over 70000 above-threshold samples
      for (int i = 0; i < 70000; i++) tick(18'sd1000, 1'b1);
      tick(18'sd0, 1'b1);
      chk("t7_valid", 32'(o_valid), 32'd1);
      chk("t7_width", 32'(o_width), 32'd65535);
      chk("t7_width8", 32'(o8_width), 32'd65535);
      chk("t7_amp", 32'(o_amp), 32'd1000);
      for (int i = 0; i < 4; i++) tick(18'sd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
